// File: rtl/ethernet_udp_tx_scheduler_pkg.sv
// Shared Ethernet types: per-frame IP/UDP header fields and the TX scheduler state.
// Imported by the scheduler and its round-robin arbiter.
package ethernet_udp_tx_scheduler_pkg;

    typedef struct packed {
        logic [47:0] dest_mac;
        logic [31:0] src_ip;
        logic [31:0] dest_ip;
        logic [15:0] src_port;
        logic [15:0] dest_port;
    } IPInfo;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_sched_state_t;

endpackage

// File: rtl/ethernet_udp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr_i,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          any_o
);

    always_comb begin
        int unsigned idx;
        idx       = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap so non-power-of-two N behaves correctly.
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/ethernet_udp_tx_scheduler.sv
// Shares one UDP transmitter between NUM_CH sources: round-robin grant, one-cycle
// send pulse, then wait for the transmitter to go busy and come back ready.
module ethernet_udp_tx_scheduler
    import ethernet_udp_tx_scheduler_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DATA_BYTES   = 16,
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_CH-1:0]              ch_valid_i,
    input  logic [NUM_CH*8*DATA_BYTES-1:0] ch_data_i,
    input  IPInfo                          ch_ip_info_i [NUM_CH],
    output logic [NUM_CH-1:0]              ch_ready_o,
    output logic [NUM_CH-1:0]              ch_done_o,
    output logic [NUM_CH-1:0]              ch_error_o,
    output logic [8*DATA_BYTES-1:0]        tx_data_o,
    output IPInfo                          tx_ip_info_o,
    output logic                           tx_send_o,
    input  logic                           tx_ready_i,
    output logic                           busy_o,
    output tx_sched_state_t                state_o
);

    localparam int DW    = 8 * DATA_BYTES;
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    tx_sched_state_t   state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  cur_q, cur_d;
    logic [IDX_W-1:0]  cur_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]     tx_data_q, tx_data_d;
    IPInfo             tx_ip_q, tx_ip_d;
    logic [NUM_CH-1:0] done_q, done_d;

    logic [NUM_CH-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [NUM_CH-1:0] ready_c;
    logic [NUM_CH-1:0] error_c;
    logic              send_c;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (IDX_W)
    ) u_rr_arbiter (
        .req_i     (ch_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    assign cur_next = (cur_q == IDX_LAST) ? '0 : cur_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        tx_ip_d   = tx_ip_q;
        done_d    = '0;
        ready_c   = '0;
        error_c   = '0;
        send_c    = 1'b0;
        case (state_q)
            IDLE: begin
                // The done pulse cycle is a spacer: the next grant comes one cycle later.
                if (tx_ready_i && gnt_any && (done_q == '0)) begin
                    ready_c   = gnt;
                    tx_data_d = ch_data_i[int'(gnt_idx)*DW +: DW];
                    tx_ip_d   = ch_ip_info_i[gnt_idx];
                    cur_d     = gnt_idx;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                send_c  = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready_i) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    error_c[cur_q] = 1'b1;
                    rr_ptr_d       = cur_next;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_ready_i) begin
                    done_d[cur_q] = 1'b1;
                    rr_ptr_d      = cur_next;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            cur_q     <= '0;
            cnt_q     <= '0;
            tx_data_q <= '0;
            tx_ip_q   <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            tx_ip_q   <= tx_ip_d;
            done_q    <= done_d;
        end
    end

    // Strobes are masked while reset is held so an aborted frame never reports.
    assign ch_ready_o   = ready_c & {NUM_CH{reset_i}};
    assign ch_error_o   = error_c & {NUM_CH{reset_i}};
    assign tx_send_o    = send_c & reset_i;
    assign ch_done_o    = done_q;
    assign tx_data_o    = tx_data_q;
    assign tx_ip_info_o = tx_ip_q;
    assign busy_o       = (state_q != IDLE);
    assign state_o      = state_q;

endmodule

// File: tb/tb_ethernet_udp_tx_scheduler.sv
// Bench for ethernet_udp_tx_scheduler: directed requests, a simple transmitter model,
// and an event scoreboard checked by an independent monitor.
module tb_ethernet_udp_tx_scheduler;
    import ethernet_udp_tx_scheduler_pkg::*;

    localparam int NUM_CH       = 4;
    localparam int DATA_BYTES   = 16;
    localparam int BUSY_TIMEOUT = 64;
    localparam int DW           = 8 * DATA_BYTES;
    localparam int BUSY_LEN     = 20;
    localparam logic [3:0] K_GRANT = 4'd0;
    localparam logic [3:0] K_DONE  = 4'd1;
    localparam logic [3:0] K_ERR   = 4'd2;

    logic                    clk_i = 1'b0;
    logic                    reset_i = 1'b0;
    logic [NUM_CH-1:0]       ch_valid_i;
    logic [NUM_CH*DW-1:0]    ch_data_i;
    IPInfo                   ch_ip_info_i [NUM_CH];
    logic [NUM_CH-1:0]       ch_ready_o, ch_done_o, ch_error_o;
    logic [DW-1:0]           tx_data_o;
    IPInfo                   tx_ip_info_o;
    logic                    tx_send_o;
    logic                    tx_ready_i;
    logic                    busy_o;
    tx_sched_state_t         state_o;

    ethernet_udp_tx_scheduler #(
        .NUM_CH(NUM_CH), .DATA_BYTES(DATA_BYTES), .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i),
        .ch_ip_info_i(ch_ip_info_i), .ch_ready_o(ch_ready_o), .ch_done_o(ch_done_o),
        .ch_error_o(ch_error_o), .tx_data_o(tx_data_o), .tx_ip_info_o(tx_ip_info_o),
        .tx_send_o(tx_send_o), .tx_ready_i(tx_ready_i), .busy_o(busy_o), .state_o(state_o)
    );

    // Clock / reset block
    always #5 clk_i = ~clk_i;

    logic [DW-1:0] data_tab [NUM_CH];
    IPInfo         ip_tab   [NUM_CH];
    logic [7:0]    exp_q[$];
    int            n_vec = 0;
    int            n_fail = 0;

    // Source model: a counted request stays valid until accepted; persist keeps it valid.
    int                req_cnt [NUM_CH];
    int                ack_cnt [NUM_CH];
    logic [NUM_CH-1:0] persist = '0;
    logic [NUM_CH-1:0] acc_pending = '0;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_valid_i[i] = persist[i] || (req_cnt[i] != ack_cnt[i]);
        end
    end

    always begin
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc_pending[i] && (req_cnt[i] != ack_cnt[i])) ack_cnt[i] = ack_cnt[i] + 1;
        end
    end

    // Transmitter model: ready drops for BUSY_LEN cycles after each accepted send.
    logic model_ready = 1'b1;
    logic hold_low = 1'b0;
    int   sends = 0;
    int   ignore_upto = 0;
    int   model_cnt = 0;
    assign tx_ready_i = model_ready && !hold_low;

    always begin
        logic s, r;
        @(negedge clk_i);
        s = tx_send_o;
        r = reset_i;
        @(posedge clk_i);
        #1;
        if (!r) begin
            model_ready = 1'b1;
            model_cnt   = 0;
        end else if (s) begin
            sends = sends + 1;
            if (sends > ignore_upto) begin
                model_ready = 1'b0;
                model_cnt   = BUSY_LEN;
            end
        end else if (!model_ready) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) model_ready = 1'b1;
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] kind, input int ch);
        exp_q.push_back({kind, 4'(ch)});
    endtask

    // Monitor / scoreboard
    int   cyc = 0;
    int   gcount = 0;
    int   grant_cyc = 0;
    int   send_cyc = 0;
    int   cur_exp = 0;
    logic send_pending = 1'b0;
    logic in_frame = 1'b0;

    task automatic pop_event(input string name, input logic [3:0] kind, input logic [NUM_CH-1:0] obs);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 160'(obs), 160'(0));
        end else begin
            e = exp_q.pop_front();
            check({name, "_kind"}, 160'(kind), 160'(e[7:4]));
            check({name, "_chan"}, 160'(obs), 160'(1) << e[3:0]);
            cur_exp = int'(e[3:0]);
        end
    endtask

    always begin
        @(negedge clk_i);
        cyc = cyc + 1;
        acc_pending = ch_valid_i & ch_ready_o;
        if (!reset_i) begin
            send_pending = 1'b0;
            in_frame     = 1'b0;
            check("reset_quiet", 160'({ch_ready_o, ch_done_o, ch_error_o, tx_send_o}), 160'(0));
        end else begin
            if (ch_ready_o != '0) begin
                pop_event("grant", K_GRANT, ch_ready_o);
                grant_cyc    = cyc;
                send_pending = 1'b1;
                gcount       = gcount + 1;
            end
            if (tx_send_o) begin
                check("send_after_grant", 160'(send_pending), 160'(1));
                check("send_latency", 160'(cyc - grant_cyc), 160'(1));
                check("tx_data", 160'(tx_data_o), 160'(data_tab[cur_exp]));
                check("tx_ip_info", 160'(tx_ip_info_o), 160'(ip_tab[cur_exp]));
                send_pending = 1'b0;
                in_frame     = 1'b1;
                send_cyc     = cyc;
            end else if (in_frame && !tx_ready_i) begin
                check("tx_data_stable", 160'(tx_data_o), 160'(data_tab[cur_exp]));
            end
            if (ch_done_o != '0) begin
                pop_event("done", K_DONE, ch_done_o);
                in_frame = 1'b0;
            end
            if (ch_error_o != '0) begin
                pop_event("error", K_ERR, ch_error_o);
                check("error_latency", 160'(cyc - send_cyc), 160'(BUSY_TIMEOUT));
                in_frame = 1'b0;
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_quiet(input int max_cyc, input string name);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!((exp_q.size() == 0) && !busy_o) && (n < max_cyc));
        if (n >= max_cyc) begin
            n_vec  = n_vec + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_grants(input int target, input int max_cyc, input string name);
        int n = 0;
        while ((gcount < target) && (n < max_cyc)) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_grant_count"}, 160'(gcount), 160'(target));
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_cnt[i] = 0;
            ack_cnt[i] = 0;
            data_tab[i] = {4{8'hA0 + 8'(i), 8'h5C, 8'(i * 17), 8'hE1 ^ 8'(i)}};
            ip_tab[i].dest_mac  = 48'h0200_0000_0010 + 48'(i);
            ip_tab[i].src_ip    = 32'hC0A8_0001;
            ip_tab[i].dest_ip   = 32'hC0A8_0064 + 32'(i);
            ip_tab[i].src_port  = 16'd5000 + 16'(i);
            ip_tab[i].dest_port = 16'h1000 + 16'(i * 3);
            ch_data_i[i*DW +: DW] = data_tab[i];
            ch_ip_info_i[i]       = ip_tab[i];
        end

        // Reset values
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_ch_ready", 160'(ch_ready_o), 160'(0));
        check("rst_ch_done", 160'(ch_done_o), 160'(0));
        check("rst_ch_error", 160'(ch_error_o), 160'(0));
        check("rst_tx_send", 160'(tx_send_o), 160'(0));
        check("rst_busy", 160'(busy_o), 160'(0));
        check("rst_tx_data", 160'(tx_data_o), 160'(0));
        check("rst_tx_ip", 160'(tx_ip_info_o), 160'(0));
        check("rst_state", 160'(state_o), 160'(IDLE));
        tick();
        reset_i = 1'b1;

        // All channels continuously valid: 0,1,2,3,0
        push(K_GRANT, 0); push(K_DONE, 0); push(K_GRANT, 1); push(K_DONE, 1);
        push(K_GRANT, 2); push(K_DONE, 2); push(K_GRANT, 3); push(K_DONE, 3);
        push(K_GRANT, 0); push(K_DONE, 0);
        tick();
        persist = 4'b1111;
        wait_grants(5, 400, "rr_all");
        tick();
        persist = 4'b0000;
        wait_quiet(100, "rr_all");

        // Single request on channel 2 (pointer at 1)
        push(K_GRANT, 2); push(K_DONE, 2);
        tick();
        req_cnt[2] = req_cnt[2] + 1;
        wait_quiet(100, "single");

        // Wrap-around: pointer 3, channels 0 and 1 pending
        push(K_GRANT, 0); push(K_DONE, 0); push(K_GRANT, 1); push(K_DONE, 1);
        tick();
        req_cnt[0] = req_cnt[0] + 1;
        req_cnt[1] = req_cnt[1] + 1;
        wait_quiet(200, "wrap");

        // Timeout on channel 2, then channel 3 served normally
        push(K_GRANT, 2); push(K_ERR, 2); push(K_GRANT, 3); push(K_DONE, 3);
        tick();
        ignore_upto = sends + 1;
        req_cnt[2] = req_cnt[2] + 1;
        req_cnt[3] = req_cnt[3] + 1;
        wait_quiet(300, "timeout");

        // Blocked launch: transmitter not ready while channel 1 is pending
        tick();
        hold_low = 1'b1;
        req_cnt[1] = req_cnt[1] + 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("blocked_ready", 160'(ch_ready_o), 160'(0));
            check("blocked_send", 160'(tx_send_o), 160'(0));
        end
        push(K_GRANT, 1); push(K_DONE, 1);
        tick();
        hold_low = 1'b0;
        wait_quiet(100, "blocked");

        // Reset in the middle of channel 3's frame
        push(K_GRANT, 3);
        tick();
        req_cnt[3] = req_cnt[3] + 1;
        begin
            int n = 0;
            while ((state_o != WAIT_DONE) && (n < 100)) begin
                @(negedge clk_i);
                n++;
            end
            check("reach_wait_done", 160'(state_o), 160'(WAIT_DONE));
        end
        tick();
        reset_i = 1'b0;
        persist = 4'b1111;
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_outputs", 160'({ch_ready_o, ch_done_o, ch_error_o, tx_send_o}), 160'(0));
        check("midrst_busy", 160'(busy_o), 160'(0));
        check("midrst_tx_data", 160'(tx_data_o), 160'(0));
        check("midrst_state", 160'(state_o), 160'(IDLE));
        check("midrst_no_pending", 160'(exp_q.size()), 160'(0));
        push(K_GRANT, 0); push(K_DONE, 0);
        tick();
        reset_i = 1'b1;
        wait_grants(gcount + 1, 50, "post_reset");
        tick();
        persist = 4'b0000;
        wait_quiet(100, "post_reset");

        repeat (3) @(negedge clk_i);
        check("final_queue_empty", 160'(exp_q.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ethernet_udp_tx_scheduler.md
# ethernet_udp_tx_scheduler

Shares one `ethernet_udp_transmit` instance between `NUM_CH` independent packet sources. Each source presents a payload plus its own `IPInfo` header fields. The scheduler picks one source round-robin, latches its request, and pulses `send` into the transmitter. It holds `data`/`ip_info` stable until the transmitter reports the frame finished, then reports completion back to the source. It sits between application producers and the single Ethernet PHY path.

## Interface
- `NUM_CH`, 4, number of requesting channels (2..8).
- `DATA_BYTES`, 16, payload width in bytes; must equal the transmitter's `DATA_BYTES`.
- `BUSY_TIMEOUT`, 64, max cycles to wait for `tx_ready` to fall after `tx_send`.

- `clk` in 1: single clock, same as the transmitter's `clk`.
- `reset` in 1: synchronous, active-low (0 = reset).
- `ch_valid` in NUM_CH: channel i has a frame pending.
- `ch_data` in NUM_CH×8·DATA_BYTES: per-channel payload, packed, channel i at `[i*8*DATA_BYTES +: 8*DATA_BYTES]`.
- `ch_ip_info` in NUM_CH×`IPInfo`: per-channel header fields (unpacked array).
- `ch_ready` out NUM_CH: one-hot accept strobe; the request is taken when `ch_valid[i] && ch_ready[i]`.
- `ch_done` out NUM_CH: one-cycle pulse when channel i's frame has left the transmitter.
- `ch_error` out NUM_CH: one-cycle pulse if channel i's frame timed out (frame dropped).
- `tx_data` out 8·DATA_BYTES: to transmitter `data`.
- `tx_ip_info` out `IPInfo`: to transmitter `ip_info`.
- `tx_send` out 1: to transmitter `send`.
- `tx_ready` in 1: from transmitter `ready`.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If `tx_ready`=1 and any `ch_valid`, the arbiter grants the first valid channel at or after `rr_ptr`, searching upward with wrap-around.
  - `ch_ready[g]` pulses for that one cycle.
  - `ch_data[g]`/`ch_ip_info[g]` are latched into `tx_data`/`tx_ip_info`, and `g` is stored as `cur`.
  - Next state: LAUNCH.
- LAUNCH: `tx_send`=1 for exactly one cycle. Timeout counter cleared. Next state: WAIT_BUSY.
- WAIT_BUSY:
  - On `tx_ready`=0 → WAIT_DONE.
  - If the counter reaches `BUSY_TIMEOUT-1` with `tx_ready` still 1, pulse `ch_error[cur]` and go to IDLE.
- WAIT_DONE: on `tx_ready`=1, pulse `ch_done[cur]`, set `rr_ptr` = `cur+1` mod NUM_CH, and go to IDLE. No timeout in this state.
- On a timeout, `rr_ptr` also advances to `cur+1`. No retry.
- `tx_data`/`tx_ip_info` change only on a grant. They hold their value through IDLE after completion.
- `ch_valid` deasserting before grant withdraws the request; no state is affected.
- `ch_valid` is ignored outside IDLE. `ch_ready` is never asserted while `busy`=1.
- Counter width is `$clog2(BUSY_TIMEOUT)`. `cur`/`rr_ptr` width is `$clog2(NUM_CH)`. Pointer increment wraps explicitly at NUM_CH; no reliance on power-of-two overflow.

## Timing
- Reset values (reset=0 sampled on a clk edge):
  - state=IDLE, `rr_ptr`=0, `cur`=0.
  - `tx_send`=0, `ch_ready`=0, `ch_done`=0, `ch_error`=0, `busy`=0.
  - `tx_data`=0, `tx_ip_info`='0.
- Grant to `tx_send`: `ch_ready` in cycle N, `tx_send` in cycle N+1. `tx_data` is valid from N+1 onward.
- `ch_done` is asserted in the cycle after `tx_ready` is sampled high in WAIT_DONE.
- A new grant is possible in the cycle after `ch_done`/`ch_error`. Minimum spacing between `tx_send` pulses is 4 cycles plus the transmitter busy time.
- If `ch_valid` rises in the same cycle `ch_done` pulses, it is eligible on the next cycle.
- Reset mid-frame: all outputs return to reset values at the next edge. No `ch_done`/`ch_error` is emitted for the aborted frame. The transmitter is reset separately by its owner.

## Structure
- `IPInfo` stays in the shared Ethernet package.
- Add the state enum `tx_sched_state_t` to the same package.
- One sub-module, `rr_arbiter`:
  - Parameterised on N.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any-grant.
  - Purely combinational, reusable.

## Test plan
- Single request: `ch_valid`=4'b0100 in IDLE with `tx_ready`=1.
  - `ch_ready`=4'b0100 for 1 cycle, then `tx_send` 1 cycle later.
  - `tx_data` = `ch_data[2]`, `tx_ip_info.dest_port` = channel 2's value.
  - `ch_done[2]` after `tx_ready` re-rises. `rr_ptr`=3.
- All channels continuously valid, using a transmitter model with ready low for 20 cycles:
  - Grant order is 0,1,2,3,0.
  - Exactly one `tx_send` per grant.
  - `tx_data` is stable for the whole busy period of each frame.
- Wrap-around: `rr_ptr`=3 with `ch_valid`=4'b0011 → channel 0 is granted, then channel 1.
- Timeout: the model never drops `tx_ready`.
  - `ch_error[cur]` pulses exactly BUSY_TIMEOUT cycles after `tx_send`.
  - State returns to IDLE with no `ch_done`, and the next channel is served.
- Reset mid-frame: assert reset in WAIT_DONE.
  - All outputs are 0 and `busy`=0 next cycle.
  - After release with `ch_valid`=4'b1111, channel 0 is granted first.
- Blocked launch: `tx_ready`=0 in IDLE with `ch_valid` high → no `ch_ready` and no `tx_send` until `tx_ready`=1.
